// File: rtl/heap_shift_engine.sv
// heap_shift_engine: sequential insert/delete engine for the processor heap area.
// Each array holds up to NArea elements plus a size register. shiftUp inserts
// a value at an index and shiftDown removes one; elements move one per clock.
// A host access port loads and reads elements while the engine is idle.
// Optional build macro HEAP_SHIFT_ENGINE_STATS_EN adds op_count/err_count.
module heap_shift_engine #(
  parameter int MemoryElementWidth = 12,
  parameter int NArea              = 8,
  parameter int NArrays            = 4,
  parameter int AW                 = (NArrays > 1) ? $clog2(NArrays) : 1,
  parameter int IW                 = $clog2(NArea + 1)
) (
  input  logic                          clock,
  input  logic                          reset,
  input  logic                          start,
  input  logic                          op,
  input  logic [AW-1:0]                 array,
  input  logic [IW-1:0]                 index,
  input  logic [MemoryElementWidth-1:0] value,
  output logic                          busy,
  output logic                          done,
  output logic                          error,
  output logic [MemoryElementWidth-1:0] result,
  output logic [IW-1:0]                 size,
  input  logic                          acc_en,
  input  logic                          acc_we,
  input  logic [AW-1:0]                 acc_array,
  input  logic [IW-1:0]                 acc_index,
  input  logic [MemoryElementWidth-1:0] acc_wdata,
  output logic [MemoryElementWidth-1:0] acc_rdata
`ifdef HEAP_SHIFT_ENGINE_STATS_EN
  ,
  output logic [15:0]                   op_count,
  output logic [15:0]                   err_count
`endif
);

  localparam int W  = MemoryElementWidth;
  localparam int EW = (NArea > 1) ? $clog2(NArea) : 1;
  localparam logic [IW-1:0] FULL = IW'(NArea);
  localparam logic [IW-1:0] ONE  = IW'(1);
  localparam logic [IW-1:0] TWO  = IW'(2);

  typedef enum logic [1:0] {IDLE, MOVE, PLACE, DONE} state_t;

  state_t stateR, stateNext;

  logic [W-1:0]  mem   [NArrays][NArea];
  logic [IW-1:0] sizes [NArrays];

  logic          opR;
  logic [AW-1:0] arrR;
  logic [EW-1:0] idxR;
  logic [EW-1:0] k;
  logic [EW-1:0] limitR;
  logic [W-1:0]  valR;
  logic [IW-1:0] sizeR;
  logic          errR;
  logic [W-1:0]  resultR;
  logic [W-1:0]  rdataR;

  logic [IW-1:0] curSize;
  logic          legal;
  logic          noMove;
  logic          accept;
  logic          accIdle;
  logic          accInRange;

  // Legality and move-count decode for the operation being offered in IDLE
  always_comb begin
    curSize    = sizes[array];
    legal      = op ? ((curSize != '0) && (index < curSize))
                    : ((curSize < FULL) && (index <= curSize));
    noMove     = op ? (index == curSize - ONE) : (index == curSize);
    accept     = (stateR == IDLE) && start;
    accIdle    = (stateR == IDLE) && !start && acc_en;
    accInRange = acc_index < FULL;
  end

  // FSM state register
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) stateR <= IDLE;
    else        stateR <= stateNext;
  end

  // FSM next-state logic; k reaching limitR marks the final move
  always_comb begin
    stateNext = stateR;
    case (stateR)
      IDLE: begin
        if (start) begin
          if (!legal)      stateNext = DONE;
          else if (noMove) stateNext = PLACE;
          else             stateNext = MOVE;
        end
      end
      MOVE:    if (k == limitR) stateNext = PLACE;
      PLACE:   stateNext = DONE;
      DONE:    stateNext = IDLE;
      default: stateNext = IDLE;
    endcase
  end

  // Operation latch, move cursor, removed-element capture and access readback
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      opR     <= 1'b0;
      arrR    <= '0;
      idxR    <= '0;
      k       <= '0;
      limitR  <= '0;
      valR    <= '0;
      sizeR   <= '0;
      errR    <= 1'b0;
      resultR <= '0;
      rdataR  <= '0;
    end else begin
      if (accept) begin
        opR     <= op;
        arrR    <= array;
        idxR    <= EW'(index);
        valR    <= value;
        sizeR   <= curSize;
        errR    <= !legal;
        resultR <= (op && legal) ? mem[array][EW'(index)] : '0;
        // shiftUp walks down from the last element; shiftDown walks up to S-2
        k       <= op ? EW'(index) : EW'(curSize - ONE);
        limitR  <= op ? EW'(curSize - TWO) : EW'(index);
      end else if (stateR == MOVE) begin
        k <= opR ? k + EW'(1) : k - EW'(1);
      end
      if (accIdle && !acc_we)
        rdataR <= accInRange ? mem[acc_array][EW'(acc_index)] : '0;
    end
  end

  // Element storage and size registers: moves, placement and host writes
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      for (int unsigned a = 0; a < NArrays; a++) begin
        sizes[a] <= '0;
        for (int unsigned e = 0; e < NArea; e++) mem[a][e] <= '0;
      end
    end else begin
      case (stateR)
        MOVE: begin
          if (opR) mem[arrR][k] <= mem[arrR][k + EW'(1)];
          else     mem[arrR][k + EW'(1)] <= mem[arrR][k];
        end
        PLACE: begin
          if (opR) begin
            mem[arrR][EW'(sizeR - ONE)] <= '0;
            sizes[arrR]                 <= sizeR - ONE;
          end else begin
            mem[arrR][idxR] <= valR;
            sizes[arrR]     <= sizeR + ONE;
          end
        end
        IDLE: begin
          if (accIdle && acc_we && accInRange) begin
            mem[acc_array][EW'(acc_index)] <= acc_wdata;
            if (acc_index >= sizes[acc_array]) sizes[acc_array] <= acc_index + ONE;
          end
        end
        default: ;
      endcase
    end
  end

  assign busy      = (stateR != IDLE);
  assign done      = (stateR == DONE);
  assign error     = (stateR == DONE) && errR;
  assign result    = resultR;
  assign acc_rdata = rdataR;
  assign size      = sizes[acc_array];

`ifdef HEAP_SHIFT_ENGINE_STATS_EN
  // Saturating completion and rejection counters
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      op_count  <= '0;
      err_count <= '0;
    end else if (stateR == DONE) begin
      if (op_count != '1) op_count <= op_count + 16'd1;
      if (errR && (err_count != '1)) err_count <= err_count + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_heap_shift_engine.sv
// Bench for heap_shift_engine: directed steps plus random operations checked
// against a queue-per-array model of the heap contents.
module tb_heap_shift_engine;

  localparam int W  = 12;
  localparam int NA = 8;
  localparam int NR = 4;
  localparam int AW = 2;
  localparam int IW = 4;

  typedef logic [W-1:0] elem_t;

  logic          clock = 1'b0;
  logic          reset = 1'b0;
  logic          start = 1'b0;
  logic          op = 1'b0;
  logic [AW-1:0] array = '0;
  logic [IW-1:0] index = '0;
  elem_t         value = '0;
  logic          busy, done, error;
  elem_t         result;
  logic [IW-1:0] size;
  logic          acc_en = 1'b0;
  logic          acc_we = 1'b0;
  logic [AW-1:0] acc_array = '0;
  logic [IW-1:0] acc_index = '0;
  elem_t         acc_wdata = '0;
  elem_t         acc_rdata;
`ifdef HEAP_SHIFT_ENGINE_STATS_EN
  logic [15:0]   op_count, err_count;
`endif

  int unsigned compared = 0;
  int unsigned mismatched = 0;

  elem_t q[NR][$];

  heap_shift_engine #(
    .MemoryElementWidth(W),
    .NArea(NA),
    .NArrays(NR)
  ) dut (
    .clock(clock), .reset(reset), .start(start), .op(op), .array(array),
    .index(index), .value(value), .busy(busy), .done(done), .error(error),
    .result(result), .size(size), .acc_en(acc_en), .acc_we(acc_we),
    .acc_array(acc_array), .acc_index(acc_index), .acc_wdata(acc_wdata),
    .acc_rdata(acc_rdata)
`ifdef HEAP_SHIFT_ENGINE_STATS_EN
    , .op_count(op_count), .err_count(err_count)
`endif
  );

  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    compared++;
    assert (obs === expv) else begin
      mismatched++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
    end
  endtask

  function automatic elem_t modelRead(input int a, input int i);
    if (i < q[a].size()) return q[a][i];
    return '0;
  endfunction

  task automatic accWrite(input int a, input int i, input elem_t d);
    @(negedge clock);
    acc_en = 1'b1; acc_we = 1'b1;
    acc_array = AW'(a); acc_index = IW'(i); acc_wdata = d;
    @(posedge clock);
    #1 acc_en = 1'b0; acc_we = 1'b0;
    if (i < NA) begin
      while (q[a].size() < i + 1) q[a].push_back('0);
      q[a][i] = d;
    end
  endtask

  task automatic accRead(input int a, input int i, input string tag);
    @(negedge clock);
    acc_en = 1'b1; acc_we = 1'b0;
    acc_array = AW'(a); acc_index = IW'(i);
    @(posedge clock);
    #1 acc_en = 1'b0;
    check(tag, acc_rdata, modelRead(a, i));
  endtask

  task automatic checkSize(input int a, input string tag);
    acc_array = AW'(a);
    #1 check(tag, size, q[a].size());
  endtask

  task automatic checkArray(input int a, input string tag);
    for (int i = 0; i < NA; i++) accRead(a, i, tag);
    checkSize(a, {tag, "_size"});
  endtask

  task automatic runOp(input bit o, input int a, input int i, input elem_t v,
                       input bit withAcc, input string tag);
    int s, moves, expLat, lat;
    bit legal;
    elem_t expRes;
    s = q[a].size();
    legal  = o ? (s > 0 && i < s) : (s < NA && i <= s);
    moves  = o ? (s - 1 - i) : (s - i);
    expLat = legal ? 2 + moves : 1;
    expRes = (o && legal) ? q[a][i] : '0;
    @(negedge clock);
    start = 1'b1; op = o; array = AW'(a); index = IW'(i); value = v;
    if (withAcc) begin
      acc_en = 1'b1; acc_we = 1'b1; acc_array = 2'd3; acc_index = 4'd7; acc_wdata = 12'hABC;
    end
    @(posedge clock);
    #1 start = 1'b0; acc_en = 1'b0; acc_we = 1'b0;
    lat = 1;
    while (done !== 1'b1 && lat < 40) begin
      @(posedge clock);
      #1 lat++;
    end
    check({tag, "_lat"}, lat, expLat);
    check({tag, "_err"}, error, !legal);
    check({tag, "_res"}, result, expRes);
    check({tag, "_busy"}, busy, 1'b1);
    if (legal) begin
      if (o) q[a].delete(i);
      else   q[a].insert(i, v);
    end
    @(posedge clock);
    #1;
    check({tag, "_doneLow"}, done, 1'b0);
    check({tag, "_idle"}, busy, 1'b0);
  endtask

  initial begin
    int lat;
    repeat (2) @(posedge clock);
    #1;
    check("rst_busy", busy, 1'b0);
    check("rst_done", done, 1'b0);
    check("rst_err", error, 1'b0);
    check("rst_res", result, '0);
    check("rst_rdata", acc_rdata, '0);
    for (int a = 0; a < NR; a++) checkSize(a, "rst_size");
    @(negedge clock) reset = 1'b1;

    // Insert in the middle
    accWrite(0, 0, 12'd0); accWrite(0, 1, 12'd1); accWrite(0, 2, 12'd2);
    checkSize(0, "load_size");
    runOp(1'b0, 0, 1, 12'd99, 1'b0, "ins");
    checkArray(0, "ins_rd");

    // Append at the end, with a simultaneous access that must be dropped
    accWrite(3, 0, 12'd0); accWrite(3, 1, 12'd1); accWrite(3, 2, 12'd2);
    runOp(1'b0, 3, 3, 12'd99, 1'b1, "app");
    checkArray(3, "app_rd");

    // Delete from the front
    accWrite(1, 0, 12'd5); accWrite(1, 1, 12'd6); accWrite(1, 2, 12'd7); accWrite(1, 3, 12'd8);
    runOp(1'b1, 1, 0, 12'd0, 1'b0, "del");
    checkArray(1, "del_rd");

    // Rejections and boundaries
    runOp(1'b1, 2, 0, 12'd0, 1'b0, "errEmpty");
    checkSize(2, "errEmpty_size");
    runOp(1'b0, 1, 5, 12'd77, 1'b0, "errIdx");
    runOp(1'b1, 1, 3, 12'd0, 1'b0, "errDelIdx");
    checkArray(1, "err_rd");
    for (int i = 0; i < NA; i++) accWrite(2, i, elem_t'(12'h770 + i));
    runOp(1'b0, 2, 0, 12'd5, 1'b0, "errFull");
    checkArray(2, "full_rd");
    runOp(1'b1, 0, 3, 12'd0, 1'b0, "delLast");
    accRead(0, 9, "rdOOR");
    accWrite(0, 8, 12'hFFF);
    checkArray(0, "wrOOR");

    // Contention: start and access while busy
    accRead(1, 0, "pre_rd");
    @(negedge clock);
    start = 1'b1; op = 1'b0; array = 2'd0; index = 4'd0; value = 12'h123;
    @(posedge clock);
    #1 start = 1'b0;
    @(negedge clock);
    start = 1'b1; op = 1'b1; array = 2'd1; index = 4'd0;
    acc_en = 1'b1; acc_we = 1'b0; acc_array = 2'd2; acc_index = 4'd7;
    @(posedge clock);
    #1;
    check("busy_rdHold", acc_rdata, 12'd6);
    check("busy_busy", busy, 1'b1);
    @(negedge clock);
    start = 1'b0; acc_we = 1'b1; acc_array = 2'd1; acc_index = 4'd0; acc_wdata = 12'h3C3;
    @(posedge clock);
    #1 acc_en = 1'b0; acc_we = 1'b0;
    lat = 0;
    while (done !== 1'b1 && lat < 40) begin
      @(posedge clock);
      #1 lat++;
    end
    check("cont_done", done, 1'b1);
    check("cont_err", error, 1'b0);
    q[0].insert(0, 12'h123);
    @(posedge clock);
    #1;
    checkArray(0, "cont_rd0");
    checkArray(1, "cont_rd1");

    // Reset during MOVE
    accRead(0, 0, "preRst_rd");
    @(negedge clock);
    start = 1'b1; op = 1'b0; array = 2'd0; index = 4'd0; value = 12'h001;
    @(posedge clock);
    #1 start = 1'b0;
    @(posedge clock);
    #2 reset = 1'b0;
    #1;
    check("arst_busy", busy, 1'b0);
    check("arst_done", done, 1'b0);
    check("arst_err", error, 1'b0);
    check("arst_res", result, '0);
    check("arst_rdata", acc_rdata, '0);
    for (int a = 0; a < NR; a++) q[a].delete();
    for (int a = 0; a < NR; a++) checkSize(a, "arst_size");
    @(negedge clock) reset = 1'b1;
    accRead(0, 0, "arst_rd0");
    accRead(2, 7, "arst_rd27");
`ifdef HEAP_SHIFT_ENGINE_STATS_EN
    check("stat_op0", op_count, 16'd0);
    check("stat_err0", err_count, 16'd0);
    runOp(1'b1, 2, 0, 12'd0, 1'b0, "statErr");
    check("stat_op1", op_count, 16'd1);
    check("stat_err1", err_count, 16'd1);
`endif

    // Random preload and operations
    for (int a = 0; a < NR; a++) begin
      int n;
      n = $urandom_range(0, NA);
      for (int i = 0; i < n; i++) accWrite(a, i, elem_t'($urandom));
    end
    for (int t = 0; t < 40; t++)
      runOp(1'($urandom_range(0, 1)), $urandom_range(0, NR - 1), $urandom_range(0, 9),
            elem_t'($urandom), 1'b0, "rnd");
    for (int a = 0; a < NR; a++) checkArray(a, "rnd_rd");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule

// File: doc/heap_shift_engine.md
Name: heap_shift_engine

Overview:
- Multi-cycle array element insert/delete engine for the heap area of the test processor.
- Holds NArrays arrays of NArea elements, each MemoryElementWidth bits wide, plus a per-array size register.
- Executes shiftUp (insert value at index, size+1) and shiftDown (remove element at index, size-1), moving one element per clock.
- Loading and readback go through a host access port while idle; replaces the inline single-cycle shiftUp loop with a bounded, checked, sequential engine.

Parameters:
- MemoryElementWidth, 12, element width W in bits.
- NArea, 8, elements per array; size range 0..NArea.
- NArrays, 4, number of arrays.
- AW, $clog2(NArrays) (minimum 1), array-select width.
- IW, $clog2(NArea+1), index/size width.

Ports:
- clock  input  1  rising-edge clock.
- reset  input  1  asynchronous, active-low reset.
- start  input  1  request an operation; sampled only in IDLE.
- op  input  1  0 = shiftUp, 1 = shiftDown.
- array  input  AW  target array.
- index  input  IW  target element position.
- value  input  W  value to insert (shiftUp).
- busy  output  1  high from the cycle after an accepted start through the done cycle.
- done  output  1  one-cycle completion pulse.
- error  output  1  valid with done: operation rejected, no state changed.
- result  output  W  removed element (shiftDown), valid with done; 0 for shiftUp.
- size  output  IW  current size of the array selected by acc_array (combinational).
- acc_en  input  1  host access strobe, honoured only in IDLE with start low.
- acc_we  input  1  1 = write, 0 = read.
- acc_array  input  AW  access array.
- acc_index  input  IW  access element.
- acc_wdata  input  W  write data.
- acc_rdata  output  W  read data, registered, one-cycle latency.

Behaviour:
- Reset (async assert, sync release): state IDLE; busy, done, error, result, acc_rdata = 0; all sizes = 0; all elements = 0.
- Reset mid-operation aborts the operation immediately with no partial-result guarantee beyond everything cleared.
- States: IDLE, MOVE, PLACE, DONE.
- IDLE, start=1 at edge T: latch op/array/index/value; k and limit are computed from the size S.
  - shiftUp legal iff S < NArea and index <= S.
  - shiftDown legal iff S > 0 and index < S.
  - Illegal: go to DONE with error=1; nothing is modified.
  - Legal, and zero moves needed: go straight to PLACE.
  - Legal otherwise: go to MOVE.
- MOVE, shiftUp: k starts at S-1 and counts down to index. Each cycle, mem[k+1] = mem[k]. There are S-index move cycles, then PLACE.
- MOVE, shiftDown: result is latched to mem[index] on the accept edge. k starts at index and counts up to S-2. Each cycle, mem[k] = mem[k+1]. There are S-1-index move cycles, then PLACE.
- PLACE, shiftUp: mem[index] = value, size = S+1.
- PLACE, shiftDown: mem[S-1] = 0, size = S-1.
- DONE: done=1 and busy=1 for exactly one cycle, then IDLE. A new start is accepted on the following edge.
- Latency: done is high in cycle T+2+moves for legal operations and T+1 for errors.
- start while not IDLE is ignored.
- acc_en while busy is ignored; acc_rdata holds its value.
- start and acc_en together in IDLE: start wins; the access is dropped.
- Access read: acc_rdata = mem[acc_array][acc_index] on the next edge. Index >= NArea returns 0.
- Access write: writes the element, and size = max(size, acc_index+1). Index >= NArea is ignored.
- Arithmetic: sizes and indices are unsigned IW bits; they never wrap because of the legality checks. Element data is stored verbatim.

Optional Feature:
- Macro: HEAP_SHIFT_ENGINE_STATS_EN.
- When defined, add outputs op_count[15:0] and err_count[15:0].
  - op_count increments on every done pulse.
  - err_count increments on every done pulse with error.
  - Both saturate at 16'hFFFF and are cleared by reset.
- When undefined, neither port nor counters exist. Core behaviour and timing are identical in both builds.

Test Plan:
- Insert: load array 0 = [0,1,2] via access writes (size 3); shiftUp index 1 value 99 at T → done at T+4, error 0; readback [0,99,1,2]; size 4.
- Append: array 0 = [0,1,2]; shiftUp index 3 value 99 → zero moves, done at T+2; contents [0,1,2,99]; size 4.
- Delete: array 1 = [5,6,7,8]; shiftDown index 0 → done at T+5, result 5; contents [6,7,8,0]; size 3.
- Errors:
  - shiftDown on empty array 2 → done at T+1, error 1, nothing changed.
  - shiftUp with index 5 on a size-3 array → error.
  - With array full (size 8), shiftUp → error.
- Contention: start while busy is ignored; acc_en while busy leaves acc_rdata unchanged.
- Reset: assert reset during MOVE → outputs 0 asynchronously, all sizes 0, readback 0. With the stats build, counters read 0 and then count 1 op / 1 err after one error operation.
